// File: rtl/sc_phase_pkg.sv
// Shared types and helpers for the two-phase non-overlapping clock generator.
package sc_phase_pkg;

    localparam int unsigned SC_CNT_W = 8;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_PH1   = 3'd1;
    localparam logic [2:0] ST_GAP12 = 3'd2;
    localparam logic [2:0] ST_PH2   = 3'd3;
    localparam logic [2:0] ST_GAP21 = 3'd4;

    typedef enum logic [2:0] {
        IDLE  = ST_IDLE,
        PH1   = ST_PH1,
        GAP12 = ST_GAP12,
        PH2   = ST_PH2,
        GAP21 = ST_GAP21
    } phase_state_t;

    typedef struct packed {
        logic [SC_CNT_W-1:0] p1;
        logic [SC_CNT_W-1:0] p2;
        logic [SC_CNT_W-1:0] g;
    } phase_cfg_t;

    // A programmed zero still yields a one-cycle phase or gap.
    function automatic logic [SC_CNT_W-1:0] eff_len(input logic [SC_CNT_W-1:0] len);
        return (len == '0) ? SC_CNT_W'(1) : len;
    endfunction

endpackage

// File: rtl/sc_phase_timer.sv
// Loadable down-counter with a zero flag; times each phase of the generator.
module sc_phase_timer #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    output logic             zero
);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (cnt != '0) begin
            cnt <= cnt - CNT_W'(1);
        end
    end

    assign zero = (cnt == '0);

endmodule

// File: rtl/sc_phase_gen.sv
// Two-phase non-overlapping clock generator with period-boundary reconfiguration.
module sc_phase_gen
    import sc_phase_pkg::*;
#(
    parameter int CNT_W  = SC_CNT_W,
    parameter int P1_RST = 4,
    parameter int P2_RST = 4,
    parameter int G_RST  = 1,
    parameter int PER_W  = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             cfg_valid,
    output logic             cfg_ready,
    input  logic [CNT_W-1:0] cfg_p1,
    input  logic [CNT_W-1:0] cfg_p2,
    input  logic [CNT_W-1:0] cfg_g,
    output logic             phi1,
    output logic             phi2,
    output logic             period_done,
    output logic             busy,
    output logic [PER_W-1:0] period_cnt
);

    phase_state_t        state;
    phase_state_t        state_nx;
    phase_cfg_t          shadow;
    phase_cfg_t          pend;
    phase_cfg_t          next_cfg;
    logic                pending;
    logic                accept;
    logic                copy;
    logic                load;
    logic                zero;
    logic [SC_CNT_W-1:0] load_len;
    logic [CNT_W-1:0]    load_val;

    assign cfg_ready   = !pending;
    assign accept      = cfg_valid && cfg_ready;
    assign busy        = (state != IDLE);
    assign period_done = (state == GAP21) && zero;
    assign copy        = pending && ((state == IDLE) || period_done);

    // PH1 entry must see the settings being copied on that same edge.
    assign next_cfg = copy ? pend : shadow;

    always_comb begin
        state_nx = state;
        load     = 1'b0;
        load_len = shadow.g;
        case (state)
            IDLE: begin
                if (en) begin
                    state_nx = PH1;
                    load     = 1'b1;
                    load_len = next_cfg.p1;
                end
            end
            PH1: begin
                if (zero) begin
                    state_nx = GAP12;
                    load     = 1'b1;
                    load_len = shadow.g;
                end
            end
            GAP12: begin
                if (zero) begin
                    state_nx = PH2;
                    load     = 1'b1;
                    load_len = shadow.p2;
                end
            end
            PH2: begin
                if (zero) begin
                    state_nx = GAP21;
                    load     = 1'b1;
                    load_len = shadow.g;
                end
            end
            GAP21: begin
                if (zero) begin
                    if (en) begin
                        state_nx = PH1;
                        load     = 1'b1;
                        load_len = next_cfg.p1;
                    end else begin
                        state_nx = IDLE;
                    end
                end
            end
            default: state_nx = IDLE;
        endcase
        load_val = CNT_W'(eff_len(load_len) - SC_CNT_W'(1));
    end

    sc_phase_timer #(
        .CNT_W(CNT_W)
    ) u_timer (
        .clk     (clk),
        .rst_n   (rst_n),
        .load    (load),
        .load_val(load_val),
        .zero    (zero)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            phi1       <= 1'b0;
            phi2       <= 1'b0;
            period_cnt <= '0;
            pending    <= 1'b0;
            pend       <= '0;
            shadow     <= '{p1: SC_CNT_W'(P1_RST), p2: SC_CNT_W'(P2_RST), g: SC_CNT_W'(G_RST)};
        end else begin
            state <= state_nx;
            phi1  <= (state_nx == PH1);
            phi2  <= (state_nx == PH2);
            if (period_done) begin
                period_cnt <= period_cnt + PER_W'(1);
            end
            // Accept and copy are exclusive: accept needs pending low, copy needs it high.
            if (copy) begin
                shadow  <= pend;
                pending <= 1'b0;
            end else if (accept) begin
                pend    <= '{p1: SC_CNT_W'(cfg_p1), p2: SC_CNT_W'(cfg_p2), g: SC_CNT_W'(cfg_g)};
                pending <= 1'b1;
            end
        end
    end

endmodule
